// File: rtl/sat_stim_gen_if.sv
// Handshake bundle for sat_stim_gen: run control in, stimulus strobe/data and status out.
// The master side requests runs; the slave side (the generator) produces the strobe.
interface sat_stim_gen_if;
  logic       start;
  logic       hold;
  logic       x;
  logic       y;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  modport master (
    output start, hold,
    input  x, y, cin, busy, done, pulse_cnt
  );

  modport slave (
    input  start, hold,
    output x, y, cin, busy, done, pulse_cnt
  );
endinterface

// File: rtl/sat_stim_gen.sv
// Stimulus generator: emits NPULSE periods of a divided strobe x, with LFSR data y/cin
// updated on each x fall so they are stable across the following x rise.
//
// state  | meaning
// S_IDLE | waiting for start, x held low
// S_RUN  | divider running, x toggling every DIV clocks
// S_DONE | one-cycle completion pulse, then back to S_IDLE
module sat_stim_gen #(
  parameter int unsigned DIV    = 2,
  parameter int unsigned NPULSE = 8,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  sat_stim_gen_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] NP       = 8'(NPULSE);

  state_t     r_state;
  logic [7:0] r_div_cnt;
  logic [7:0] r_pulse_cnt;
  logic [7:0] r_lfsr;
  logic       r_x;
  logic       r_y;
  logic       r_cin;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_lfsr_next;
  logic       w_wrap;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_wrap      = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= 8'd0;
      r_pulse_cnt <= 8'd0;
      r_lfsr      <= SEED;
      r_x         <= 1'b0;
      r_y         <= 1'b0;
      r_cin       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_lfsr      <= SEED;
            r_div_cnt   <= 8'd0;
            r_pulse_cnt <= 8'd0;
            if (NP == 8'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // hold freezes everything, including a coincident wrap or terminal fall
          if (!bus.hold) begin
            if (w_wrap) begin
              r_div_cnt <= 8'd0;
              r_x       <= ~r_x;
              if (!r_x) begin
                r_pulse_cnt <= r_pulse_cnt + 8'd1;
              end else begin
                r_lfsr <= w_lfsr_next;
                r_y    <= w_lfsr_next[0];
                r_cin  <= w_lfsr_next[1];
                if (r_pulse_cnt == NP) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            end else begin
              r_div_cnt <= r_div_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.cin       = r_cin;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pulse_cnt = r_pulse_cnt;

`ifdef FORMAL
  logic f_first = 1'b1;
  always_ff @(posedge clk) f_first <= 1'b0;

  always_comb begin
    if (f_first) assume (rst);
  end

  a_x_on_wrap: assert property (@(posedge clk) disable iff (rst)
    (r_x != $past(r_x)) |-> $past(r_state == S_RUN && w_wrap && !bus.hold));

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
    !(r_busy && r_done));

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    r_pulse_cnt <= NP);

  a_live: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_IDLE && bus.start) |-> s_eventually r_done);
`endif

endmodule

// File: tb/tb_sat_stim_gen.sv
// Self-checking bench for sat_stim_gen: four parameterisations checked every cycle against
// a phase-time reference model, plus directed runs for the documented scenarios.
module tb_sat_stim_gen;

  localparam int NK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic r_start [NK];
  logic r_hold  [NK];

  int n_chk  = 0;
  int n_fail = 0;

  sat_stim_gen_if bus_a ();
  sat_stim_gen_if bus_b ();
  sat_stim_gen_if bus_c ();
  sat_stim_gen_if bus_d ();

  assign bus_a.start = r_start[0];
  assign bus_a.hold  = r_hold[0];
  assign bus_b.start = r_start[1];
  assign bus_b.hold  = r_hold[1];
  assign bus_c.start = r_start[2];
  assign bus_c.hold  = r_hold[2];
  assign bus_d.start = r_start[3];
  assign bus_d.hold  = r_hold[3];

  sat_stim_gen #(.DIV(2), .NPULSE(3), .SEED(8'hA5)) u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  sat_stim_gen #(.DIV(1), .NPULSE(5), .SEED(8'h3C)) u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  sat_stim_gen #(.DIV(3), .NPULSE(0), .SEED(8'h5A)) u_c (.clk(clk), .rst(rst), .bus(bus_c.slave));
  sat_stim_gen #(.DIV(3), .NPULSE(4), .SEED(8'h81)) u_d (.clk(clk), .rst(rst), .bus(bus_d.slave));

  function automatic int p_div(int k);
    case (k)
      0: return 2;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int p_np(int k);
    case (k)
      0: return 3;
      1: return 5;
      2: return 0;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] p_seed(int k);
    case (k)
      0: return 8'hA5;
      1: return 8'h3C;
      2: return 8'h5A;
      default: return 8'h81;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_adv(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Model: phase (0 idle, 1 run, 2 done) and t = unheld clocks since run entry.
  // x, rises and falls all follow arithmetically from t.
  int         m_ph   [NK];
  int         m_t    [NK];
  int         m_cnt  [NK];
  logic [7:0] m_lfsr [NK];
  logic       m_y    [NK];
  logic       m_cin  [NK];

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int k);
    m_ph[k]   = 0;
    m_t[k]    = 0;
    m_cnt[k]  = 0;
    m_lfsr[k] = p_seed(k);
    m_y[k]    = 1'b0;
    m_cin[k]  = 1'b0;
  endtask

  task automatic model_step();
    int per;
    for (int k = 0; k < NK; k++) begin
      per = 2 * p_div(k);
      if (rst) begin
        model_reset(k);
      end else begin
        case (m_ph[k])
          0: begin
            if (r_start[k]) begin
              m_t[k]    = 0;
              m_cnt[k]  = 0;
              m_lfsr[k] = p_seed(k);
              m_ph[k]   = (p_np(k) == 0) ? 2 : 1;
            end
          end
          1: begin
            if (!r_hold[k]) begin
              m_t[k]++;
              if (m_t[k] % per == p_div(k)) m_cnt[k]++;
              if (m_t[k] % per == 0) begin
                m_lfsr[k] = lfsr_adv(m_lfsr[k]);
                m_y[k]    = m_lfsr[k][0];
                m_cin[k]  = m_lfsr[k][1];
              end
              if (m_t[k] == per * p_np(k)) m_ph[k] = 2;
            end
          end
          default: m_ph[k] = 0;
        endcase
      end
    end
  endtask

  task automatic get_obs(int k, output logic x, output logic y, output logic cin,
                         output logic busy, output logic done, output logic [7:0] cnt);
    case (k)
      0: begin x = bus_a.x; y = bus_a.y; cin = bus_a.cin; busy = bus_a.busy; done = bus_a.done; cnt = bus_a.pulse_cnt; end
      1: begin x = bus_b.x; y = bus_b.y; cin = bus_b.cin; busy = bus_b.busy; done = bus_b.done; cnt = bus_b.pulse_cnt; end
      2: begin x = bus_c.x; y = bus_c.y; cin = bus_c.cin; busy = bus_c.busy; done = bus_c.done; cnt = bus_c.pulse_cnt; end
      default: begin x = bus_d.x; y = bus_d.y; cin = bus_d.cin; busy = bus_d.busy; done = bus_d.done; cnt = bus_d.pulse_cnt; end
    endcase
  endtask

  task automatic compare_all();
    logic x, y, cin, busy, done;
    logic [7:0] cnt;
    int exp_x;
    for (int k = 0; k < NK; k++) begin
      get_obs(k, x, y, cin, busy, done, cnt);
      exp_x = (m_ph[k] == 1) ? ((m_t[k] / p_div(k)) % 2) : 0;
      chk($sformatf("x[%0d]", k),    int'(x),    exp_x);
      chk($sformatf("y[%0d]", k),    int'(y),    int'(m_y[k]));
      chk($sformatf("cin[%0d]", k),  int'(cin),  int'(m_cin[k]));
      chk($sformatf("busy[%0d]", k), int'(busy), int'(m_ph[k] == 1));
      chk($sformatf("done[%0d]", k), int'(done), int'(m_ph[k] == 2));
      chk($sformatf("cnt[%0d]", k),  int'(cnt),  m_cnt[k]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int blen, ndone, nfall, hold_left, cnt_at_hold, first_done, second_rise, found;
    logic prev_x, prev_busy, seen_high, xdrop, cntmove;
    logic [1:0] fy, fc;
    logic [3:0] pat;

    for (int k = 0; k < NK; k++) begin
      r_start[k] = 1'b0;
      r_hold[k]  = 1'b0;
      model_reset(k);
    end
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // basic run on DIV=2, NPULSE=3, SEED=A5
    blen = 0; ndone = 0; nfall = 0; prev_x = 1'b0; fy = '0; fc = '0;
    r_start[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      r_start[0] = 1'b0;
      if (bus_a.busy) blen++;
      if (bus_a.done) ndone++;
      if (prev_x && !bus_a.x) begin
        if (nfall < 2) begin
          fy[nfall] = bus_a.y;
          fc[nfall] = bus_a.cin;
        end
        nfall++;
      end
      prev_x = bus_a.x;
    end
    chk("basic_busy_len", blen, 12);
    chk("basic_done_cnt", ndone, 1);
    chk("basic_final_cnt", int'(bus_a.pulse_cnt), 3);
    chk("basic_falls", nfall, 3);
    chk("lfsr_fall1_y", int'(fy[0]), 0);
    chk("lfsr_fall1_cin", int'(fc[0]), 1);
    chk("lfsr_fall2_y", int'(fy[1]), 1);
    chk("lfsr_fall2_cin", int'(fc[1]), 0);

    // hold for 5 clocks right after an x rise
    blen = 0; seen_high = 1'b0; hold_left = 0; xdrop = 1'b0; cntmove = 1'b0; cnt_at_hold = 0;
    r_start[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      r_start[0] = 1'b0;
      if (bus_a.busy) blen++;
      if (!seen_high && bus_a.x) begin
        seen_high   = 1'b1;
        r_hold[0]   = 1'b1;
        hold_left   = 5;
        cnt_at_hold = int'(bus_a.pulse_cnt);
      end else if (hold_left > 0) begin
        if (!bus_a.x) xdrop = 1'b1;
        if (int'(bus_a.pulse_cnt) != cnt_at_hold) cntmove = 1'b1;
        hold_left--;
        if (hold_left == 0) r_hold[0] = 1'b0;
      end
    end
    chk("hold_seen_x_high", int'(seen_high), 1);
    chk("hold_x_dropped", int'(xdrop), 0);
    chk("hold_cnt_moved", int'(cntmove), 0);
    chk("hold_busy_len", blen, 17);

    // NPULSE=0: done on the start edge, x never moves
    r_start[2] = 1'b1;
    cyc();
    r_start[2] = 1'b0;
    chk("np0_done", int'(bus_c.done), 1);
    chk("np0_busy", int'(bus_c.busy), 0);
    cyc();
    chk("np0_done_cleared", int'(bus_c.done), 0);
    chk("np0_x", int'(bus_c.x), 0);

    // DIV=1: x toggles every clock
    r_start[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      r_start[1] = 1'b0;
      pat[3 - i] = bus_b.x;
    end
    chk("div1_pattern", int'(pat), 4'b0101);
    repeat (12) cyc();

    // asynchronous reset mid-run at pulse_cnt=2, then restart reproduces the sequence
    found = 0;
    r_start[0] = 1'b1;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cyc();
      r_start[0] = 1'b0;
      if (bus_a.pulse_cnt == 8'd2) found = 1;
    end
    chk("rst_reach_cnt2", found, 1);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NK; k++) model_reset(k);
    chk("rst_x_now", int'(bus_a.x), 0);
    chk("rst_busy_now", int'(bus_a.busy), 0);
    chk("rst_cnt_now", int'(bus_a.pulse_cnt), 0);
    compare_all();
    cyc();
    rst = 1'b0;
    cyc();
    found = 0; prev_x = 1'b0;
    r_start[0] = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc();
      r_start[0] = 1'b0;
      if (prev_x && !bus_a.x) begin
        found = 1;
        chk("restart_fall1_y", int'(bus_a.y), 0);
        chk("restart_fall1_cin", int'(bus_a.cin), 1);
      end
      prev_x = bus_a.x;
    end
    chk("restart_fall_seen", found, 1);
    repeat (20) cyc();

    // start held high: back-to-back runs separated by DONE and one IDLE clock
    ndone = 0; first_done = -1; second_rise = -1; prev_busy = 1'b0;
    r_start[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus_a.done) begin
        ndone++;
        if (first_done < 0) first_done = i;
      end
      if (bus_a.busy && !prev_busy && first_done >= 0 && second_rise < 0) second_rise = i;
      prev_busy = bus_a.busy;
    end
    r_start[0] = 1'b0;
    chk("held_done_cnt", ndone, 2);
    chk("held_first_done", first_done, 12);
    chk("held_restart_gap", second_rise - first_done, 2);
    repeat (20) cyc();

    // randomized traffic on all instances, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NK; k++) begin
        r_start[k] = ($urandom_range(0, 7) == 0);
        r_hold[k]  = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    for (int k = 0; k < NK; k++) begin
      r_start[k] = 1'b0;
      r_hold[k]  = 1'b0;
    end
    repeat (40) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
